fetch_stage: RTL and testbench

//  Y86-64 PIPE fetch stage. Selects f_pc from predicted PC or M/W redirects and drives it to instructionMemory.

---
 rtl/fetch_stage.sv | 222 ++++++++++++++++++++++
 tb/tb_fetch_stage.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage -- Y86-64 PIPE fetch stage
//
// Picks the fetch PC. The candidates are the predicted PC, the fall-through
// PC of a mispredicted jXX in M, and the return address of a ret in W. The
// 10 instruction bytes returned for that PC are split into icode/ifun,
// register IDs, valC and valP. The stage then predicts the next PC and loads
// the decode results into the D pipeline register.
//
// A small FETCH/STOPPED state machine stops fetching after a non-AOK
// instruction (halt, bad address, illegal instruction) enters D. Only a
// redirect from M or W can restart it, because that halt may have been
// fetched on a mispredicted path.
//
// Ports
//   clk, reset           clock; synchronous active-high reset
//   f_pc                 fetch PC driven to instruction memory (combinational)
//   valRead0..valRead9   instruction bytes at f_pc .. f_pc+9
//   imem_error           instruction memory address error for f_pc
//   F_stall              hold predicted PC
//   D_stall, D_bubble    hold D register / load a bubble into D
//   M_icode, M_Cnd,      mispredicted-branch redirect from M
//   M_valA
//   W_icode, W_valM      ret redirect from W
//   D_stat .. D_valP     D pipeline register contents
//   f_stopped            high while the stage is STOPPED
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] f_pc,
  input  logic [7:0]  valRead0,
  input  logic [7:0]  valRead1,
  input  logic [7:0]  valRead2,
  input  logic [7:0]  valRead3,
  input  logic [7:0]  valRead4,
  input  logic [7:0]  valRead5,
  input  logic [7:0]  valRead6,
  input  logic [7:0]  valRead7,
  input  logic [7:0]  valRead8,
  input  logic [7:0]  valRead9,
  input  logic        imem_error,
  input  logic        F_stall,
  input  logic        D_stall,
  input  logic        D_bubble,
  input  logic [3:0]  M_icode,
  input  logic        M_Cnd,
  input  logic [63:0] M_valA,
  input  logic [3:0]  W_icode,
  input  logic [63:0] W_valM,
  output logic [2:0]  D_stat,
  output logic [3:0]  D_icode,
  output logic [3:0]  D_ifun,
  output logic [3:0]  D_rA,
  output logic [3:0]  D_rB,
  output logic [63:0] D_valC,
  output logic [63:0] D_valP,
  output logic        f_stopped
);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] I_HALT = 4'h0;
  localparam logic [3:0] I_NOP  = 4'h1;
  localparam logic [3:0] I_JXX  = 4'h7;
  localparam logic [3:0] I_CALL = 4'h8;
  localparam logic [3:0] I_RET  = 4'h9;
  localparam logic [3:0] R_NONE = 4'hF;

  typedef enum logic [0:0] {
    S_FETCH   = 1'b0,
    S_STOPPED = 1'b1
  } state_t;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valC;
    logic [63:0] valP;
  } d_reg_t;

  localparam d_reg_t BUBBLE = '{
    stat:  STAT_AOK,
    icode: I_NOP,
    ifun:  4'h0,
    rA:    R_NONE,
    rB:    R_NONE,
    valC:  64'd0,
    valP:  64'd0
  };

  state_t      state, state_next;
  logic [63:0] pred_pc;
  d_reg_t      d_reg;

  // Fetch-side signals
  logic        redirect_m, redirect_w, redirect;
  logic        fetching, load_d;
  d_reg_t      f_dec;
  logic        need_regids, need_valC, ifun_ok;
  logic [63:0] f_pred;

  // ---------------- PC select ----------------
  assign redirect_m = (M_icode == I_JXX) && !M_Cnd;
  assign redirect_w = (W_icode == I_RET);
  assign redirect   = redirect_m || redirect_w;

  always_comb begin
    if (redirect_m)      f_pc = M_valA;
    else if (redirect_w) f_pc = W_valM;
    else                 f_pc = pred_pc;
  end

  // A redirect restarts fetching even from STOPPED.
  assign fetching = (state == S_FETCH) || redirect;
  assign load_d   = fetching && !D_stall && !D_bubble;

  // ---------------- Decode of the fetched bytes ----------------
  always_comb begin
    // NOTE: every variable gets a default first so no path through this
    // block leaves one unassigned, which would infer a latch.
    f_dec = BUBBLE;

    f_dec.icode = imem_error ? I_NOP : valRead0[7:4];
    f_dec.ifun  = imem_error ? 4'h0  : valRead0[3:0];

    need_regids = f_dec.icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
    need_valC   = f_dec.icode inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8};

    f_dec.rA = need_regids ? valRead1[7:4] : R_NONE;
    f_dec.rB = need_regids ? valRead1[3:0] : R_NONE;

    // valC is little-endian and starts right after the register byte, if any.
    if (!need_valC)
      f_dec.valC = 64'd0;
    else if (need_regids)
      f_dec.valC = {valRead9, valRead8, valRead7, valRead6,
                    valRead5, valRead4, valRead3, valRead2};
    else
      f_dec.valC = {valRead8, valRead7, valRead6, valRead5,
                    valRead4, valRead3, valRead2, valRead1};

    f_dec.valP = f_pc + 64'd1 + {63'd0, need_regids} + (need_valC ? 64'd8 : 64'd0);

    // Only the OPq/cmovXX/jXX families use non-zero function codes.
    case (f_dec.icode)
      4'h2, 4'h7: ifun_ok = (f_dec.ifun <= 4'h6);
      4'h6:       ifun_ok = (f_dec.ifun <= 4'h3);
      default:    ifun_ok = (f_dec.ifun == 4'h0);
    endcase

    if (imem_error)                           f_dec.stat = STAT_ADR;
    else if (!(f_dec.icode <= 4'hB && ifun_ok)) f_dec.stat = STAT_INS;
    else if (f_dec.icode == I_HALT)           f_dec.stat = STAT_HLT;
    else                                      f_dec.stat = STAT_AOK;

    f_pred = (f_dec.icode == I_JXX || f_dec.icode == I_CALL) ? f_dec.valC : f_dec.valP;
  end

  // ---------------- Predicted PC register ----------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, regardless of statement order.
    if (reset)
      pred_pc <= RESET_PC;
    else if (!F_stall && fetching)
      pred_pc <= f_pred;
  end

  // ---------------- D pipeline register ----------------
  always_ff @(posedge clk) begin
    if (reset)
      d_reg <= BUBBLE;
    else if (D_stall)
      d_reg <= d_reg;
    else if (D_bubble || !fetching)
      d_reg <= BUBBLE;
    else
      d_reg <= f_dec;
  end

  assign D_stat  = d_reg.stat;
  assign D_icode = d_reg.icode;
  assign D_ifun  = d_reg.ifun;
  assign D_rA    = d_reg.rA;
  assign D_rB    = d_reg.rB;
  assign D_valC  = d_reg.valC;
  assign D_valP  = d_reg.valP;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state;
    unique case (state)
      S_FETCH:
        if (load_d && f_dec.stat != STAT_AOK) state_next = S_STOPPED;
      S_STOPPED:
        // A redirected fetch resumes unless it too loads a non-AOK instruction.
        if (redirect)
          state_next = (load_d && f_dec.stat != STAT_AOK) ? S_STOPPED : S_FETCH;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    f_stopped = (state == S_STOPPED);
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] f_pc;
  logic [7:0]  valRead0, valRead1, valRead2, valRead3, valRead4;
  logic [7:0]  valRead5, valRead6, valRead7, valRead8, valRead9;
  logic        imem_error;
  logic        F_stall, D_stall, D_bubble;
  logic [3:0]  M_icode;
  logic        M_Cnd;
  logic [63:0] M_valA;
  logic [3:0]  W_icode;
  logic [63:0] W_valM;
  logic [2:0]  D_stat;
  logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
  logic [63:0] D_valC, D_valP;
  logic        f_stopped;

  always #5 clk = ~clk;

  // 256-byte instruction memory; addresses >= 256 report an address error.
  logic [7:0] mem [256];
  logic       force_err;

  assign valRead0 = mem[f_pc[7:0]];
  assign valRead1 = mem[f_pc[7:0] + 8'd1];
  assign valRead2 = mem[f_pc[7:0] + 8'd2];
  assign valRead3 = mem[f_pc[7:0] + 8'd3];
  assign valRead4 = mem[f_pc[7:0] + 8'd4];
  assign valRead5 = mem[f_pc[7:0] + 8'd5];
  assign valRead6 = mem[f_pc[7:0] + 8'd6];
  assign valRead7 = mem[f_pc[7:0] + 8'd7];
  assign valRead8 = mem[f_pc[7:0] + 8'd8];
  assign valRead9 = mem[f_pc[7:0] + 8'd9];
  assign imem_error = force_err || (f_pc >= 64'd256);

  fetch_stage #(.RESET_PC(64'd0)) dut (
    .clk(clk), .reset(reset), .f_pc(f_pc),
    .valRead0(valRead0), .valRead1(valRead1), .valRead2(valRead2),
    .valRead3(valRead3), .valRead4(valRead4), .valRead5(valRead5),
    .valRead6(valRead6), .valRead7(valRead7), .valRead8(valRead8),
    .valRead9(valRead9), .imem_error(imem_error),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
    .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valA(M_valA),
    .W_icode(W_icode), .W_valM(W_valM),
    .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun),
    .D_rA(D_rA), .D_rB(D_rB), .D_valC(D_valC), .D_valP(D_valP),
    .f_stopped(f_stopped)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- Reference model ----------------
  typedef struct {
    logic [2:0]  stat;
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp, next;
  } inst_t;

  localparam inst_t BUB = '{stat: 3'd1, icode: 4'h1, ifun: 4'h0, ra: 4'hF, rb: 4'hF,
                            valc: 64'd0, valp: 64'd0, next: 64'd0};

  logic [63:0] m_pred;
  inst_t       m_d;
  bit          m_stopped;
  bit          m_valid = 0;

  // Instruction lengths and field layout from the Y86-64 encoding table.
  function automatic inst_t decode(input logic [63:0] pc, input bit err);
    inst_t      r;
    logic [7:0] b [10];
    logic [7:0] a;
    int         regs, hasc;
    bit         ok;
    for (int i = 0; i < 10; i++) begin
      a    = pc[7:0] + 8'(i);
      b[i] = mem[a];
    end
    r.icode = err ? 4'h1 : b[0][7:4];
    r.ifun  = err ? 4'h0 : b[0][3:0];
    regs = (r.icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB}) ? 1 : 0;
    hasc = (r.icode inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8}) ? 1 : 0;
    r.ra = (regs == 1) ? b[1][7:4] : 4'hF;
    r.rb = (regs == 1) ? b[1][3:0] : 4'hF;
    r.valc = 64'd0;
    if (hasc == 1)
      for (int k = 0; k < 8; k++) r.valc = r.valc | (64'(b[1 + regs + k]) << (8 * k));
    r.valp = pc + 64'(1 + regs + 8 * hasc);
    if (r.icode == 4'h2 || r.icode == 4'h7) ok = (r.ifun < 7);
    else if (r.icode == 4'h6)               ok = (r.ifun < 4);
    else                                    ok = (r.icode < 12) && (r.ifun == 0);
    if (r.icode > 4'hB) ok = 0;
    if (err)           r.stat = 3'd3;
    else if (!ok)      r.stat = 3'd4;
    else if (r.icode == 0) r.stat = 3'd2;
    else               r.stat = 3'd1;
    r.next = (r.icode == 4'h7 || r.icode == 4'h8) ? r.valc : r.valp;
    return r;
  endfunction

  function automatic logic [63:0] model_pc();
    if (M_icode == 4'h7 && !M_Cnd) return M_valA;
    if (W_icode == 4'h9)           return W_valM;
    return m_pred;
  endfunction

  // One clock: inputs must already be applied; checks f_pc before the edge
  // and the registered outputs #1 after it.
  task automatic step();
    logic [63:0] pc;
    inst_t       dec;
    bit          redir, active;
    #1;
    pc    = model_pc();
    redir = (M_icode == 4'h7 && !M_Cnd) || (W_icode == 4'h9);
    if (m_valid) chk("f_pc", f_pc, pc);
    dec = decode(pc, force_err || (pc >= 64'd256));
    if (reset) begin
      m_pred = 64'd0; m_d = BUB; m_stopped = 0; m_valid = 1;
    end else if (m_valid) begin
      active = !m_stopped || redir;
      if (!D_stall) m_d = (D_bubble || !active) ? BUB : dec;
      if (!F_stall && active) m_pred = dec.next;
      if (active) m_stopped = !D_stall && !D_bubble && (dec.stat != 3'd1);
    end
    @(posedge clk);
    #1;
    if (m_valid) begin
      chk("D_stat",    D_stat,    m_d.stat);
      chk("D_icode",   D_icode,   m_d.icode);
      chk("D_ifun",    D_ifun,    m_d.ifun);
      chk("D_rA",      D_rA,      m_d.ra);
      chk("D_rB",      D_rB,      m_d.rb);
      chk("D_valC",    D_valC,    m_d.valc);
      chk("D_valP",    D_valP,    m_d.valp);
      chk("f_stopped", f_stopped, m_stopped);
    end
  endtask

  task automatic restart();
    reset = 1; step(); reset = 0;
  endtask

  task automatic put_irmovq10();
    mem[0] = 8'h30; mem[1] = 8'hF2; mem[2] = 8'h0A;
    for (int i = 3; i < 10; i++) mem[i] = 8'h00;
  endtask

  initial begin
    reset = 1; force_err = 0;
    F_stall = 0; D_stall = 0; D_bubble = 0;
    M_icode = 4'h1; M_Cnd = 0; M_valA = 64'd0;
    W_icode = 4'h1; W_valM = 64'd0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h10;

    // 1: irmovq $10, %rdx
    put_irmovq10();
    restart();
    chk("t1_reset_icode", D_icode, 64'h1);
    chk("t1_reset_pc", f_pc, 64'd0);
    step();
    chk("t1_icode", D_icode, 64'h3);
    chk("t1_rB", D_rB, 64'h2);
    chk("t1_rA", D_rA, 64'hF);
    chk("t1_valC", D_valC, 64'd10);
    chk("t1_valP", D_valP, 64'd10);
    chk("t1_pred", f_pc, 64'd10);

    // 2: jmp 0x20, then mispredict redirect to 9
    mem[0] = 8'h70; mem[1] = 8'h20;
    for (int i = 2; i < 10; i++) mem[i] = 8'h00;
    restart();
    step();
    chk("t2_valP", D_valP, 64'd9);
    chk("t2_pred", f_pc, 64'h20);
    M_icode = 4'h7; M_Cnd = 0; M_valA = 64'd9;
    #1 chk("t2_redirect", f_pc, 64'd9);
    step();
    M_icode = 4'h1;

    // 3: halt stops the stage; ret redirect restarts it
    mem[0] = 8'h00;
    restart();
    step();
    chk("t3_hlt", D_stat, 64'd2);
    chk("t3_stopped", f_stopped, 64'd1);
    step();
    chk("t3_bubble", D_icode, 64'h1);
    step();
    W_icode = 4'h9; W_valM = 64'h40;
    #1 chk("t3_ret_pc", f_pc, 64'h40);
    step();
    chk("t3_resumed", f_stopped, 64'd0);
    W_icode = 4'h1;

    // 4: invalid icode, invalid jXX ifun, valid OPq
    mem[0] = 8'hC0; restart(); step();
    chk("t4_ins_icode", D_stat, 64'd4);
    mem[0] = 8'h77; restart(); step();
    chk("t4_ins_ifun", D_stat, 64'd4);
    mem[0] = 8'h61; mem[1] = 8'h23; restart(); step();
    chk("t4_aok", D_stat, 64'd1);

    // 5: memory error, then stall and bubble
    force_err = 1; restart(); step();
    chk("t5_adr", D_stat, 64'd3);
    chk("t5_nop", D_icode, 64'h1);
    force_err = 0;
    put_irmovq10();
    restart(); step();
    D_stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_stall_icode", D_icode, 64'h3);
      chk("t5_stall_valC", D_valC, 64'd10);
    end
    D_stall = 0; D_bubble = 1;
    step();
    chk("t5_bub_icode", D_icode, 64'h1);
    chk("t5_bub_valP", D_valP, 64'd0);
    D_bubble = 0;

    // 6: reset while STOPPED
    mem[0] = 8'h00; restart(); step(); step();
    chk("t6_stopped", f_stopped, 64'd1);
    restart();
    chk("t6_unstopped", f_stopped, 64'd0);
    chk("t6_pc", f_pc, 64'd0);
    chk("t6_bub_rA", D_rA, 64'hF);

    // Random phase: mostly well-formed opcodes, random control.
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom);
      if ($urandom_range(0, 1) == 0) mem[i] = {4'($urandom_range(1, 11)), 4'h0};
    end
    for (int c = 0; c < 3000; c++) begin
      reset     = ($urandom_range(0, 99) == 0);
      force_err = ($urandom_range(0, 31) == 0);
      F_stall   = ($urandom_range(0, 9) == 0);
      D_stall   = ($urandom_range(0, 9) == 0);
      D_bubble  = ($urandom_range(0, 9) == 0);
      M_icode   = 4'($urandom_range(0, 15));
      M_Cnd     = ($urandom_range(0, 3) != 0);
      M_valA    = 64'($urandom_range(0, 300));
      W_icode   = ($urandom_range(0, 9) == 0) ? 4'h9 : 4'h1;
      W_valM    = 64'($urandom_range(0, 300));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
